// File: rtl/display_scan_controller.sv
// ---------------------------------------------------------------------------
// display_scan_controller
//
// Purpose:
//   Time-multiplexes one shared two-digit 7-segment decoder across the six
//   physical digits (HH:MM:SS) of the alarm clock. It selects time or alarm
//   as the source and snapshots the values once per frame, so digits never
//   tear. It scans the digits with a dark gap at the start of every slot
//   (anti-ghosting) and blinks the field currently being edited.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   en           in   1   1 = scan, 0 = blank display and hold counters cleared
//   disp_mode    in   1   0 = time H/M/S, 1 = alarm H/M with seconds blank
//   edit_field   in   2   0 none, 1 hours, 2 minutes, 3 seconds (blinks)
//   time_h/m/s   in   7   current time, binary
//   alarm_h/m    in   7   alarm setting, binary
//   dec_in       out  7   value presented to the shared decoder
//   dec_out      in  14   decoder result, [13:7] tens, [6:0] ones
//   seg          out  7   segments a..g, active-high
//   dig_n        out  6   digit enables, active-low, [5]=H tens .. [0]=S ones
//   frame_start  out  1   one-cycle pulse in the LOAD cycle of slot 5
// ---------------------------------------------------------------------------
module display_scan_controller #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 4,
    parameter int BLINK_DIV = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        disp_mode,
    input  logic [1:0]  edit_field,
    input  logic [6:0]  time_h,
    input  logic [6:0]  time_m,
    input  logic [6:0]  time_s,
    input  logic [6:0]  alarm_h,
    input  logic [6:0]  alarm_m,
    output logic [6:0]  dec_in,
    input  logic [13:0] dec_out,
    output logic [6:0]  seg,
    output logic [5:0]  dig_n,
    output logic        frame_start
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);
    localparam logic [BLK_W-1:0] BLINK_LAST     = BLK_W'(BLINK_DIV - 1);
    localparam logic [BLK_W-1:0] BLINK_ONE      = BLK_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        BLANK,
        SHOW
    } state_t;

    state_t           state_q,       state_d;
    logic [2:0]       slot_q,        slot_d;
    logic [CNT_W-1:0] slot_cnt_q,    slot_cnt_d;
    logic [BLK_W-1:0] frame_cnt_q,   frame_cnt_d;
    logic             blink_ph_q,    blink_ph_d;
    logic [6:0]       snap_h_q,      snap_h_d;
    logic [6:0]       snap_m_q,      snap_m_d;
    logic [6:0]       snap_s_q,      snap_s_d;
    logic             snap_mode_q,   snap_mode_d;
    logic [1:0]       snap_field_q,  snap_field_d;
    logic             snap_blink_q,  snap_blink_d;
    logic [6:0]       dec_in_q,      dec_in_d;
    logic [6:0]       seg_q,         seg_d;
    logic [5:0]       dig_n_q,       dig_n_d;
    logic             frame_start_q, frame_start_d;

    // Live source selection, only sampled at the frame boundary.
    logic [6:0] sel_h;
    logic [6:0] sel_m;
    logic [6:0] sel_s;
    logic [6:0] dec_half;

    assign sel_h    = disp_mode ? alarm_h : time_h;
    assign sel_m    = disp_mode ? alarm_m : time_m;
    assign sel_s    = disp_mode ? 7'd0    : time_s;
    // Odd slots are tens digits, even slots are ones digits.
    assign dec_half = slot_q[0] ? dec_out[13:7] : dec_out[6:0];

    // Which digit pair a slot belongs to, using edit_field encoding
    // (1 = hours, 2 = minutes, 3 = seconds).
    function automatic logic [1:0] pair_of(input logic [2:0] slot);
        if (slot >= 3'd4) begin
            pair_of = 2'd1;
        end else if (slot >= 3'd2) begin
            pair_of = 2'd2;
        end else begin
            pair_of = 2'd3;
        end
    endfunction

    // Digit-enable pattern for a slot. A suppressed slot keeps every
    // digit off for the whole slot; otherwise exactly one bit is low.
    function automatic logic [5:0] lit_mask(
        input logic [2:0] slot,
        input logic       mode,
        input logic [1:0] field,
        input logic       blink
    );
        logic off;
        off = (mode && (slot <= 3'd1)) ||
              (blink && (field != 2'd0) && (field == pair_of(slot)));
        lit_mask = off ? 6'h3F : ~(6'd1 << slot);
    endfunction

    // Next-state logic for the scan FSM, counters, snapshots and outputs.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        slot_cnt_d    = slot_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        blink_ph_d    = blink_ph_q;
        snap_h_d      = snap_h_q;
        snap_m_d      = snap_m_q;
        snap_s_d      = snap_s_q;
        snap_mode_d   = snap_mode_q;
        snap_field_d  = snap_field_q;
        snap_blink_d  = snap_blink_q;
        dec_in_d      = dec_in_q;
        seg_d         = seg_q;
        dig_n_d       = dig_n_q;
        frame_start_d = 1'b0;

        if (!en) begin
            state_d     = IDLE;
            slot_d      = 3'd5;
            slot_cnt_d  = '0;
            frame_cnt_d = '0;
            blink_ph_d  = 1'b0;
            dec_in_d    = 7'd0;
            seg_d       = 7'd0;
            dig_n_d     = 6'h3F;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d       = LOAD;
                    slot_d        = 3'd5;
                    slot_cnt_d    = '0;
                    frame_start_d = 1'b1;
                end

                LOAD: begin
                    slot_cnt_d = CNT_ONE;
                    if (slot_q == 3'd5) begin
                        // The frame uses the blink phase from before this
                        // boundary's update, so the first frame after enable
                        // counts toward a full lit half-period.
                        snap_h_d     = sel_h;
                        snap_m_d     = sel_m;
                        snap_s_d     = sel_s;
                        snap_mode_d  = disp_mode;
                        snap_field_d = edit_field;
                        snap_blink_d = blink_ph_q;
                        if (frame_cnt_q == BLINK_LAST) begin
                            frame_cnt_d = '0;
                            blink_ph_d  = ~blink_ph_q;
                        end else begin
                            frame_cnt_d = frame_cnt_q + BLINK_ONE;
                        end
                        dec_in_d = sel_h;
                    end else if (slot_q == 3'd4) begin
                        dec_in_d = snap_h_q;
                    end else if (slot_q >= 3'd2) begin
                        dec_in_d = snap_m_q;
                    end else begin
                        dec_in_d = snap_s_q;
                    end
                    if (BLANK_CYC == 1) begin
                        state_d = SHOW;
                        dig_n_d = lit_mask(slot_q, snap_mode_d, snap_field_d,
                                           snap_blink_d);
                    end else begin
                        state_d = BLANK;
                    end
                end

                BLANK: begin
                    seg_d      = dec_half;
                    slot_cnt_d = slot_cnt_q + CNT_ONE;
                    if (slot_cnt_q == CNT_BLANK_LAST) begin
                        state_d = SHOW;
                        dig_n_d = lit_mask(slot_q, snap_mode_q, snap_field_q,
                                           snap_blink_q);
                    end
                end

                SHOW: begin
                    // With no BLANK cycles the decoder result is only
                    // ready one cycle into SHOW, so latch it there.
                    if ((BLANK_CYC == 1) && (slot_cnt_q == CNT_ONE)) begin
                        seg_d = dec_half;
                    end
                    if (slot_cnt_q == CNT_LAST) begin
                        slot_cnt_d    = '0;
                        dig_n_d       = 6'h3F;
                        state_d       = LOAD;
                        slot_d        = (slot_q == 3'd0) ? 3'd5 : slot_q - 3'd1;
                        frame_start_d = (slot_q == 3'd0);
                    end else begin
                        slot_cnt_d = slot_cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    dig_n_d = 6'h3F;
                end
            endcase
        end
    end

    // All state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            slot_q        <= 3'd5;
            slot_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            blink_ph_q    <= 1'b0;
            snap_h_q      <= 7'd0;
            snap_m_q      <= 7'd0;
            snap_s_q      <= 7'd0;
            snap_mode_q   <= 1'b0;
            snap_field_q  <= 2'd0;
            snap_blink_q  <= 1'b0;
            dec_in_q      <= 7'd0;
            seg_q         <= 7'd0;
            dig_n_q       <= 6'h3F;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            slot_cnt_q    <= slot_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_ph_q    <= blink_ph_d;
            snap_h_q      <= snap_h_d;
            snap_m_q      <= snap_m_d;
            snap_s_q      <= snap_s_d;
            snap_mode_q   <= snap_mode_d;
            snap_field_q  <= snap_field_d;
            snap_blink_q  <= snap_blink_d;
            dec_in_q      <= dec_in_d;
            seg_q         <= seg_d;
            dig_n_q       <= dig_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign dec_in      = dec_in_q;
    assign seg         = seg_q;
    assign dig_n       = dig_n_q;
    assign frame_start = frame_start_q;

endmodule
